alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// RV64IM ALU decode-and-issue controller: registers the decode of one accepted
// instruction, pulses start for mul/div, and sequences completion by class latency.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 64,
  parameter int unsigned M_EN    = 1,
  parameter int unsigned CNT_W   = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [2:0]  select,
  output logic [1:0]  control,
  output logic        word,
  output logic        illegal,
  output logic        start,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  localparam logic [2:0] SEL_MUL = 3'b001;
  localparam logic [2:0] SEL_DIV = 3'b010;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept;

  logic [2:0]       dec_sel;
  logic [1:0]       dec_ctl;
  logic             dec_word;
  logic             dec_ill;
  logic [CNT_W-1:0] dec_cnt;

  logic [2:0]       select_nx;
  logic [1:0]       control_nx;
  logic             word_nx, illegal_nx, start_nx, busy_nx, out_valid_nx, in_ready_nx;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] f6;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign f3            = instr[14:12];
  assign f7            = instr[31:25];
  assign f6            = instr[31:26];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Instruction decode; any unmatched encoding collapses to illegal 000/00.
  always_comb begin
    dec_sel  = 3'b000;
    dec_ctl  = 2'b00;
    dec_word = 1'b0;
    dec_ill  = 1'b0;
    unique case (opcode)
      OPC_LOAD:  dec_ill = (f3 == 3'b111);
      OPC_STORE: dec_ill = f3[2];
      OPC_OPIMM, OPC_OPIMM32: begin
        dec_word = (opcode == OPC_OPIMM32);
        unique case (f3)
          3'b000: ;
          3'b001: if (f6 == 6'b000000) dec_sel = 3'b011; else dec_ill = 1'b1;
          3'b101: begin
            if (f6 == 6'b000000)      dec_sel = 3'b100;
            else if (f6 == 6'b010000) begin dec_sel = 3'b100; dec_ctl = 2'b01; end
            else                      dec_ill = 1'b1;
          end
          3'b010: if (!dec_word) dec_ctl = 2'b10; else dec_ill = 1'b1;
          3'b011: if (!dec_word) dec_ctl = 2'b11; else dec_ill = 1'b1;
          3'b100: if (!dec_word) dec_sel = 3'b101; else dec_ill = 1'b1;
          3'b110: if (!dec_word) dec_sel = 3'b110; else dec_ill = 1'b1;
          default: if (!dec_word) dec_sel = 3'b111; else dec_ill = 1'b1;
        endcase
      end
      OPC_OP, OPC_OP32: begin
        dec_word = (opcode == OPC_OP32);
        unique case (f7)
          7'b0000000: begin
            unique case (f3)
              3'b000: ;
              3'b001: dec_sel = 3'b011;
              3'b101: dec_sel = 3'b100;
              3'b010: if (!dec_word) dec_ctl = 2'b10; else dec_ill = 1'b1;
              3'b011: if (!dec_word) dec_ctl = 2'b11; else dec_ill = 1'b1;
              3'b100: if (!dec_word) dec_sel = 3'b101; else dec_ill = 1'b1;
              3'b110: if (!dec_word) dec_sel = 3'b110; else dec_ill = 1'b1;
              default: if (!dec_word) dec_sel = 3'b111; else dec_ill = 1'b1;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      dec_ctl = 2'b01;
            else if (f3 == 3'b101) begin dec_sel = 3'b100; dec_ctl = 2'b01; end
            else                   dec_ill = 1'b1;
          end
          7'b0000001: begin
            if (M_EN == 0)                        dec_ill = 1'b1;
            else if (f3[2])                       begin dec_sel = SEL_DIV; dec_ctl = f3[1:0]; end
            else if (!dec_word || f3 == 3'b000)   begin dec_sel = SEL_MUL; dec_ctl = f3[1:0]; end
            else                                  dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_sel  = 3'b000;
      dec_ctl  = 2'b00;
      dec_word = 1'b0;
    end
  end

  always_comb begin
    dec_cnt = '0;
    if (dec_sel == SEL_MUL)      dec_cnt = MUL_CNT;
    else if (dec_sel == SEL_DIV) dec_cnt = DIV_CNT;
  end

  assign accept = (state == IDLE) && in_ready && in_valid && !flush;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      select    <= 3'b000;
      control   <= 2'b00;
      word      <= 1'b0;
      illegal   <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      select    <= select_nx;
      control   <= control_nx;
      word      <= word_nx;
      illegal   <= illegal_nx;
      start     <= start_nx;
      busy      <= busy_nx;
      out_valid <= out_valid_nx;
      in_ready  <= in_ready_nx;
    end
  end

  // Next state; flush wins over everything but reset.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          state_nx = EXEC;
          cnt_nx   = dec_cnt;
        end
        EXEC: if (cnt == '0) state_nx = DONE;
              else           cnt_nx   = cnt - CNT_W'(1);
        DONE: if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next output values; decode fields move only on acceptance.
  always_comb begin
    select_nx    = select;
    control_nx   = control;
    word_nx      = word;
    illegal_nx   = illegal;
    start_nx     = 1'b0;
    if (accept) begin
      select_nx  = dec_sel;
      control_nx = dec_ctl;
      word_nx    = dec_word;
      illegal_nx = dec_ill;
      start_nx   = !dec_ill && (dec_sel == SEL_MUL || dec_sel == SEL_DIV);
    end
    busy_nx      = (state_nx != IDLE);
    out_valid_nx = (state_nx == DONE);
    in_ready_nx  = (state_nx == IDLE);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: scoreboard of expected decode and completion
// cycle per accepted op, plus reset, flush and M_EN=0 scenarios.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, word, illegal, start, busy, out_valid;
  logic [2:0]  select;
  logic [1:0]  control;

  logic        n_in_valid, n_out_ready;
  logic [31:0] n_instr;
  logic        n_in_ready, n_word, n_illegal, n_start, n_busy, n_out_valid;
  logic [2:0]  n_select;
  logic [1:0]  n_control;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [6:0]  dec;
    int unsigned done;
  } exp_t;
  exp_t sb[$];

  alu_issue_ctrl #(.MUL_LAT(3), .DIV_LAT(64), .M_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .select(select), .control(control), .word(word), .illegal(illegal),
    .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready));

  alu_issue_ctrl #(.MUL_LAT(3), .DIV_LAT(64), .M_EN(0)) u_nom (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .instr(n_instr), .select(n_select), .control(n_control), .word(n_word),
    .illegal(n_illegal), .start(n_start), .busy(n_busy), .out_valid(n_out_valid),
    .out_ready(n_out_ready));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec_now();
    return {select, control, word, illegal};
  endfunction

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!in_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Issue one op, check launch, completion cycle, decode, hold and release.
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [6:0] dec,
                        input int lat, input int hold);
    exp_t e;
    int   starts = 0;
    int   rdy = 0;
    bit   seen = 0;
    wait_ready(300);
    in_valid = 1'b1;
    instr    = ins;
    @(negedge clk);
    in_valid = 1'b0;
    instr    = $urandom;
    e.dec  = dec;
    e.done = cyc + lat;
    sb.push_back(e);
    chk({tag, "_start"}, 32'(start),
        32'((dec[6:4] == 3'b001 || dec[6:4] == 3'b010) && !dec[0]));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < lat + 20; i++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      starts += int'(start);
      rdy    += int'(in_ready);
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    chk({tag, "_lat"}, cyc, e.done);
    chk({tag, "_dec"}, 32'(dec_now()), 32'(e.dec));
    chk({tag, "_extra_start"}, 32'(starts), 32'd0);
    chk({tag, "_ready_low"}, 32'(rdy), 32'd0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_dec"}, 32'(dec_now()), 32'(e.dec));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int unsigned t;
    int          cnt_v;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_instr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_outs", 32'({dec_now(), start, busy, out_valid}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    run_op("add",   32'h003100B3, 7'b0000000, 1, 0);
    run_op("divu",  32'h023150B3, 7'b0100100, 64, 0);
    run_op("sraiw", 32'h4050D09B, 7'b1000110, 1, 0);
    run_op("srai_bad", 32'h4450D093, 7'b0000001, 1, 0);
    run_op("mulw",  32'h023100BB, 7'b0010010, 3, 5);
    run_op("mul",   32'h023100B3, 7'b0010000, 3, 0);
    run_op("sub",   32'h403100B3, 7'b0000100, 1, 0);
    run_op("sltu",  32'h003130B3, 7'b0001100, 1, 2);
    run_op("ld",    32'h0000B083, 7'b0000000, 1, 0);
    run_op("andi",  32'h0FF0F093, 7'b1110000, 1, 0);
    run_op("lui",   32'h000010B7, 7'b0000001, 1, 0);
    run_op("remuw", 32'h0231F0BB, 7'b0101110, 64, 0);

    // M_EN=0: mul is illegal, single-cycle, never launches
    n_in_valid = 1'b1;
    n_instr    = 32'h023100B3;
    @(negedge clk);
    n_in_valid = 1'b0;
    t = cyc;
    chk("nom_start", 32'(n_start), 32'd0);
    chk("nom_dec", 32'({n_select, n_control, n_word, n_illegal}), 32'h01);
    @(negedge clk);
    chk("nom_valid", 32'(n_out_valid), 32'd1);
    chk("nom_lat", cyc, t + 1);
    n_out_ready = 1'b1;
    @(negedge clk);
    n_out_ready = 1'b0;
    chk("nom_rel", 32'({n_out_valid, n_in_ready}), 32'b01);

    // Reset mid-divide aborts with no late completion
    wait_ready(10);
    in_valid = 1'b1;
    instr    = 32'h023150B3;
    @(negedge clk);
    in_valid = 1'b0;
    t = cyc;
    while (cyc < t + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", 32'({start, busy, out_valid, in_ready}), 32'd0);
    chk("rst_mid_dec", 32'(dec_now()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    cnt_v = 0;
    repeat (80) begin
      @(negedge clk);
      cnt_v += int'(out_valid) + int'(busy);
    end
    chk("rst_no_stale", 32'(cnt_v), 32'd0);

    // Flush mid-divide, coincident in_valid ignored, then a fresh add
    in_valid = 1'b1;
    instr    = 32'h023150B3;
    @(negedge clk);
    in_valid = 1'b0;
    t = cyc;
    while (cyc < t + 2) @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'h003100B3;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_outs", 32'({start, busy, out_valid, in_ready}), 32'b0001);
    chk("flush_dec_kept", 32'(dec_now()), 32'b0100100);
    run_op("add_after_flush", 32'h003100B3, 7'b0000000, 1, 0);

    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'h403100B3;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle_noacc", 32'({busy, in_ready}), 32'b01);
    chk("flush_idle_dec", 32'(dec_now()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
